cdc_src_flush_ctrl: RTL and testbench

- Single-clock stage sitting directly upstream of the clearable 2-phase CDC, in the source clock domain.
- Buffers the producer stream in a small FIFO and drives the CDC source port (data/valid/ready, clear, clear_pending).
- On a clear request it isolates the stream, issues a one-cycle CDC clear with valid guaranteed low, flushes its FIFO and waits for the CDC clear sequence to finish before reporting completion.

---
 rtl/cdc_src_flush_ctrl_if.sv | 32 +++
 rtl/cdc_src_flush_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cdc_src_flush_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_src_flush_ctrl_if.sv
// Source-domain link bundle between the producer, the flush controller and
// the clearable 2-phase CDC source port. The controller sits on the slave
// side; the producer/CDC environment sits on the master side.
interface cdc_src_flush_ctrl_if #(
    parameter type T     = logic,
    parameter int  CNT_W = 16
);
    T                 data_i;
    logic             valid_i;
    logic             ready_o;
    T                 cdc_data_o;
    logic             cdc_valid_o;
    logic             cdc_ready_i;
    logic             cdc_clear_o;
    logic             cdc_clear_pending_i;
    logic             clear_req_i;
    logic             clear_busy_o;
    logic             clear_done_o;
    logic [CNT_W-1:0] dropped_cnt_o;

    modport master (
        output data_i, valid_i, cdc_ready_i, cdc_clear_pending_i, clear_req_i,
        input  ready_o, cdc_data_o, cdc_valid_o, cdc_clear_o,
               clear_busy_o, clear_done_o, dropped_cnt_o
    );

    modport slave (
        input  data_i, valid_i, cdc_ready_i, cdc_clear_pending_i, clear_req_i,
        output ready_o, cdc_data_o, cdc_valid_o, cdc_clear_o,
               clear_busy_o, clear_done_o, dropped_cnt_o
    );
endinterface

// File: rtl/cdc_src_flush_ctrl.sv
// Source-domain front end of the clearable CDC: buffers the producer stream
// in a small FIFO and, on request, isolates the stream, fires a one-cycle CDC
// clear, flushes the FIFO (counting discarded entries) and waits for the CDC
// clear sequence to finish before signalling completion.
module cdc_src_flush_ctrl #(
    parameter type         T            = logic,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PEND_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cdc_src_flush_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(PEND_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e           state_r;
    state_e           state_s;
    T                 mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    wr_ptr_s;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic [TW-1:0]    tmo_r;
    logic [TW-1:0]    tmo_s;
    logic [CNT_W-1:0] dropped_r;
    logic [CNT_W-1:0] dropped_s;
    logic             ready_r;
    logic             valid_r;
    logic             clear_r;
    logic             busy_r;
    logic             done_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Saturating add of a flushed occupancy onto the dropped-entry counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [AW:0]      inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Handshakes only ever complete in IDLE because ready/valid are gated by state.
    assign wr_en_s = bus.valid_i & ready_r;
    assign rd_en_s = valid_r & bus.cdc_ready_i;

    // Next-state, FIFO bookkeeping and flush accounting.
    always_comb begin
        state_s   = state_r;
        rd_ptr_s  = rd_ptr_r;
        tmo_s     = tmo_r;
        dropped_s = dropped_r;
        if (wr_en_s) begin
            wr_ptr_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        count_s = count_r + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);

        case (state_r)
            ST_IDLE: begin
                if (bus.clear_req_i) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Stream is isolated here, so the occupancy is exactly what gets discarded.
                rd_ptr_s  = wr_ptr_r;
                count_s   = '0;
                dropped_s = sat_add(dropped_r, count_r);
                tmo_s     = '0;
                state_s   = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.cdc_clear_pending_i || (tmo_r == TW'(PEND_TIMEOUT - 1))) begin
                    tmo_s   = '0;
                    state_s = ST_WAIT_LO;
                end else begin
                    tmo_s   = tmo_r + TW'(1);
                    state_s = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (bus.cdc_clear_pending_i) begin
                    state_s = ST_WAIT_LO;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean, empty IDLE.
                rd_ptr_s = wr_ptr_r;
                count_s  = '0;
                tmo_s    = '0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State, pointers, counters and registered outputs derived from next-state values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            tmo_r     <= '0;
            dropped_r <= '0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            clear_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            count_r   <= count_s;
            tmo_r     <= tmo_s;
            dropped_r <= dropped_s;
            ready_r   <= (state_s == ST_IDLE) && (count_s != (AW+1)'(DEPTH));
            valid_r   <= (state_s == ST_IDLE) && (count_s != '0);
            clear_r   <= (state_s == ST_ISSUE);
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // FIFO storage; contents are only meaningful where the occupancy says so.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.data_i;
        end
    end

    assign bus.ready_o       = ready_r;
    assign bus.cdc_valid_o   = valid_r;
    assign bus.cdc_data_o    = mem_r[rd_ptr_r];
    assign bus.cdc_clear_o   = clear_r;
    assign bus.clear_busy_o  = busy_r;
    assign bus.clear_done_o  = done_r;
    assign bus.dropped_cnt_o = dropped_r;
endmodule

// File: tb/tb_cdc_src_flush_ctrl.sv
// Directed bench for cdc_src_flush_ctrl: streaming, backpressure, clear with
// data, pending timeout, same-cycle clear boundary, counter saturation
// (on a narrow-counter instance) and asynchronous reset mid-sequence.
module tb_cdc_src_flush_ctrl;
    logic       clk = 1'b0;
    logic       rst_ni;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] got [8];
    int         n_got;
    logic       acc;

    always #5 clk = ~clk;

    cdc_src_flush_ctrl_if #(.T(logic [7:0]), .CNT_W(16)) bus  ();
    cdc_src_flush_ctrl_if #(.T(logic [7:0]), .CNT_W(2))  bus2 ();

    cdc_src_flush_ctrl #(
        .T(logic [7:0]), .DEPTH(4), .PEND_TIMEOUT(16), .CNT_W(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    cdc_src_flush_ctrl #(
        .T(logic [7:0]), .DEPTH(4), .PEND_TIMEOUT(1), .CNT_W(2)
    ) dut2 (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic push2(input logic [7:0] d);
        bus2.data_i  = d;
        bus2.valid_i = 1'b1;
        tick();
        bus2.valid_i = 1'b0;
    endtask

    // Ticks until clear_done_o is seen on the selected instance, at most 40 cycles.
    task automatic wait_done(input int sel, input string tag);
        logic s;
        s = 1'b0;
        for (int i = 0; i < 40 && !s; i++) begin
            tick();
            if (sel == 1) s = bus.clear_done_o;
            else          s = bus2.clear_done_o;
        end
        check(tag, 32'(s), 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0;
        bus.data_i = 8'h00;  bus.valid_i = 1'b0;  bus.cdc_ready_i = 1'b0;
        bus.cdc_clear_pending_i = 1'b0;  bus.clear_req_i = 1'b0;
        bus2.data_i = 8'h00; bus2.valid_i = 1'b0; bus2.cdc_ready_i = 1'b0;
        bus2.cdc_clear_pending_i = 1'b0; bus2.clear_req_i = 1'b0;
        #12;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_valid", 32'(bus.cdc_valid_o), 32'd0);
        check("rst_clear", 32'(bus.cdc_clear_o), 32'd0);
        check("rst_busy",  32'(bus.clear_busy_o), 32'd0);
        check("rst_done",  32'(bus.clear_done_o), 32'd0);
        check("rst_drop",  32'(bus.dropped_cnt_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Streaming: each word appears the cycle after acceptance.
        bus.cdc_ready_i = 1'b1;
        push(8'h11);
        check("s1_valid", 32'(bus.cdc_valid_o), 32'd1);
        check("s1_data",  32'(bus.cdc_data_o), 32'h11);
        check("s1_ready", 32'(bus.ready_o), 32'd1);
        push(8'h22);
        check("s2_data",  32'(bus.cdc_data_o), 32'h22);
        check("s2_ready", 32'(bus.ready_o), 32'd1);
        push(8'h33);
        check("s3_data",  32'(bus.cdc_data_o), 32'h33);
        check("s3_ready", 32'(bus.ready_o), 32'd1);
        tick();
        check("s_empty",  32'(bus.cdc_valid_o), 32'd0);

        // Backpressure: four words fill the FIFO, the fifth is held upstream.
        bus.cdc_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(8'(i + 1));
            check($sformatf("full_ready%0d", i), 32'(bus.ready_o), (i < 3) ? 32'd1 : 32'd0);
        end
        bus.data_i  = 8'h05;
        bus.valid_i = 1'b1;
        tick();
        check("full_hold_ready", 32'(bus.ready_o), 32'd0);
        check("full_hold_data",  32'(bus.cdc_data_o), 32'h01);
        bus.cdc_ready_i = 1'b1;
        n_got = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cdc_valid_o && n_got < 8) begin
                got[n_got] = bus.cdc_data_o;
                n_got++;
            end
            acc = bus.valid_i & bus.ready_o;
            tick();
            if (acc) bus.valid_i = 1'b0;
        end
        check("drain_count", 32'(n_got), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_word%0d", i), 32'(got[i]), 32'(i + 1));
        end

        // Clear with three words buffered; CDC pending high for 10 cycles.
        bus.cdc_ready_i = 1'b0;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("c_valid_pre", 32'(bus.cdc_valid_o), 32'd1);
        bus.clear_req_i = 1'b1;
        tick();
        bus.clear_req_i = 1'b0;
        check("c_issue_clear", 32'(bus.cdc_clear_o), 32'd1);
        check("c_issue_valid", 32'(bus.cdc_valid_o), 32'd0);
        check("c_issue_ready", 32'(bus.ready_o), 32'd0);
        check("c_issue_busy",  32'(bus.clear_busy_o), 32'd1);
        tick();
        check("c_clear_1cyc", 32'(bus.cdc_clear_o), 32'd0);
        check("c_dropped",    32'(bus.dropped_cnt_o), 32'd3);
        tick();
        bus.cdc_clear_pending_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("c_busy%0d", i), 32'(bus.clear_busy_o), 32'd1);
            check($sformatf("c_nodone%0d", i), 32'(bus.clear_done_o), 32'd0);
        end
        bus.cdc_clear_pending_i = 1'b0;
        tick();
        check("c_done",      32'(bus.clear_done_o), 32'd1);
        check("c_done_busy", 32'(bus.clear_busy_o), 32'd1);
        tick();
        check("c_done_pulse", 32'(bus.clear_done_o), 32'd0);
        check("c_idle_busy",  32'(bus.clear_busy_o), 32'd0);
        check("c_idle_ready", 32'(bus.ready_o), 32'd1);
        check("c_idle_empty", 32'(bus.cdc_valid_o), 32'd0);

        // Pending never rises: done 16 cycles after WAIT_HI entry plus one.
        bus.clear_req_i = 1'b1;
        tick();
        bus.clear_req_i = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t_nodone%0d", i), 32'(bus.clear_done_o), 32'd0);
        end
        tick();
        check("t_done", 32'(bus.clear_done_o), 32'd1);
        tick();
        check("t_ready", 32'(bus.ready_o), 32'd1);
        check("t_empty", 32'(bus.cdc_valid_o), 32'd0);
        check("t_drop",  32'(bus.dropped_cnt_o), 32'd3);

        // Clear request in the same cycle as a read handshake and a write.
        push(8'h55);
        check("b_head", 32'(bus.cdc_data_o), 32'h55);
        bus.cdc_ready_i = 1'b1;
        bus.data_i      = 8'h66;
        bus.valid_i     = 1'b1;
        bus.clear_req_i = 1'b1;
        tick();
        bus.cdc_ready_i = 1'b0;
        bus.valid_i     = 1'b0;
        bus.clear_req_i = 1'b0;
        check("b_issue_clear", 32'(bus.cdc_clear_o), 32'd1);
        tick();
        check("b_dropped", 32'(bus.dropped_cnt_o), 32'd4);
        wait_done(1, "b_done");
        tick();
        check("b_empty", 32'(bus.cdc_valid_o), 32'd0);

        // Asynchronous reset while waiting for pending to fall.
        push(8'hB1);
        push(8'hB2);
        bus.clear_req_i = 1'b1;
        tick();
        bus.clear_req_i = 1'b0;
        tick();
        bus.cdc_clear_pending_i = 1'b1;
        tick();
        check("r_busy_pre", 32'(bus.clear_busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("r_ready", 32'(bus.ready_o), 32'd1);
        check("r_valid", 32'(bus.cdc_valid_o), 32'd0);
        check("r_clear", 32'(bus.cdc_clear_o), 32'd0);
        check("r_busy",  32'(bus.clear_busy_o), 32'd0);
        check("r_drop",  32'(bus.dropped_cnt_o), 32'd0);
        bus.cdc_clear_pending_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("r_nodone", 32'(bus.clear_done_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("r_nodone_after", 32'(bus.clear_done_o), 32'd0);
        bus.cdc_ready_i = 1'b1;
        push(8'h77);
        check("r_stream_valid", 32'(bus.cdc_valid_o), 32'd1);
        check("r_stream_data",  32'(bus.cdc_data_o), 32'h77);
        tick();
        check("r_stream_empty", 32'(bus.cdc_valid_o), 32'd0);

        // Saturation on the 2-bit counter instance: 2 + 2 clamps at 3.
        push2(8'hC1);
        push2(8'hC2);
        bus2.clear_req_i = 1'b1;
        tick();
        bus2.clear_req_i = 1'b0;
        wait_done(2, "sat_done1");
        tick();
        check("sat_drop1", 32'(bus2.dropped_cnt_o), 32'd2);
        push2(8'hC3);
        push2(8'hC4);
        bus2.clear_req_i = 1'b1;
        tick();
        bus2.clear_req_i = 1'b0;
        wait_done(2, "sat_done2");
        tick();
        check("sat_drop2",  32'(bus2.dropped_cnt_o), 32'd3);
        check("sat_ready",  32'(bus2.ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
